// File: rtl/alu_sequencer.sv
// Bus initiator for the ArgonALU: takes one operation request, walks the ALU through
// its latch/compute/read command sequence and returns result and flags to the client.
module alu_sequencer #(
    parameter int WORDSIZE  = 16,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [WORDSIZE-1:0]  i_req_a,
    input  logic [WORDSIZE-1:0]  i_req_b,
    input  logic [3:0]           i_req_op,
    input  logic                 i_req_use_flags,
    input  logic [7:0]           i_req_flags,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [WORDSIZE-1:0]  o_resp_result,
    output logic [7:0]           o_resp_flags,
    output logic                 o_resp_error,
    output logic [CMD_WIDTH-1:0] o_bus_command,
    output logic [WORDSIZE-1:0]  o_bus_data,
    output logic                 o_bus_valid,
    input  logic [WORDSIZE-1:0]  i_bus_data,
    input  logic                 i_bus_valid
);

    localparam logic [CMD_WIDTH-1:0] COM_NOP     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHA  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHB  = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHOP = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHF  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] COM_COMPUTE = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] COM_OUTPUTY = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] COM_OUTPUTF = CMD_WIDTH'(7);

    // Last counter value before a stalled read is abandoned.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_A, S_LD_B, S_LD_OP, S_LD_F, S_COMPUTE, S_RD_Y, S_RD_F, S_RESP
    } state_t;

    typedef struct packed {
        logic [WORDSIZE-1:0] a;
        logic [WORDSIZE-1:0] b;
        logic [3:0]          op;
        logic                use_flags;
        logic [7:0]          flags;
    } req_t;

    state_t     state;
    req_t       req_q;
    logic [3:0] tmo_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= S_IDLE;
            req_q         <= '0;
            tmo_cnt       <= '0;
            o_req_ready   <= 1'b1;
            o_resp_valid  <= 1'b0;
            o_resp_result <= '0;
            o_resp_flags  <= '0;
            o_resp_error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        req_q       <= '{a: i_req_a, b: i_req_b, op: i_req_op,
                                         use_flags: i_req_use_flags, flags: i_req_flags};
                        o_req_ready <= 1'b0;
                        state       <= S_LD_A;
                    end
                end
                S_LD_A:  state <= S_LD_B;
                S_LD_B:  state <= S_LD_OP;
                S_LD_OP: state <= req_q.use_flags ? S_LD_F : S_COMPUTE;
                S_LD_F:  state <= S_COMPUTE;
                S_COMPUTE: begin
                    tmo_cnt <= '0;
                    state   <= S_RD_Y;
                end
                S_RD_Y: begin
                    if (i_bus_valid) begin
                        o_resp_result <= i_bus_data;
                        tmo_cnt       <= '0;
                        state         <= S_RD_F;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_resp_result <= '0;
                        o_resp_error  <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= S_RD_F;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                S_RD_F: begin
                    if (i_bus_valid) begin
                        o_resp_flags <= i_bus_data[7:0];
                        o_resp_valid <= 1'b1;
                        state        <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_resp_flags <= '0;
                        o_resp_error <= 1'b1;
                        o_resp_valid <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    // Error stays visible for the whole response and clears on the way back.
                    if (i_resp_ready) begin
                        o_resp_valid <= 1'b0;
                        o_resp_error <= 1'b0;
                        o_req_ready  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    o_req_ready  <= 1'b1;
                    o_resp_valid <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_bus_command = COM_NOP;
        o_bus_data    = '0;
        o_bus_valid   = 1'b0;
        case (state)
            S_LD_A: begin
                o_bus_command = COM_LATCHA;
                o_bus_data    = req_q.a;
                o_bus_valid   = 1'b1;
            end
            S_LD_B: begin
                o_bus_command = COM_LATCHB;
                o_bus_data    = req_q.b;
                o_bus_valid   = 1'b1;
            end
            S_LD_OP: begin
                o_bus_command = COM_LATCHOP;
                o_bus_data    = WORDSIZE'(req_q.op);
                o_bus_valid   = 1'b1;
            end
            S_LD_F: begin
                o_bus_command = COM_LATCHF;
                o_bus_data    = WORDSIZE'(req_q.flags);
                o_bus_valid   = 1'b1;
            end
            S_COMPUTE: o_bus_command = COM_COMPUTE;
            S_RD_Y:    o_bus_command = COM_OUTPUTY;
            S_RD_F:    o_bus_command = COM_OUTPUTF;
            default:   o_bus_command = COM_NOP;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the command bus.
module tb_alu_sequencer;

    localparam logic [3:0] C_NOP = 4'd0, C_LA = 4'd1, C_LB = 4'd2, C_LOP = 4'd3, C_LF = 4'd4,
                           C_CMP = 4'd5, C_OY = 4'd6, C_OF = 4'd7;
    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_op = '0;
    logic        req_uf = 1'b0;
    logic [7:0]  req_fl = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_error;
    logic [15:0] resp_result;
    logic [7:0]  resp_flags;
    logic [3:0]  bus_cmd;
    logic [15:0] bus_dout, bus_din;
    logic        bus_vout, bus_vin;

    int total = 0;
    int bad   = 0;
    int lat;
    logic [3:0]  cmdlog[$];
    logic [15:0] datlog[$];
    logic        stall_y = 1'b0;
    logic [15:0] hold_res;

    always #5 clk = ~clk;

    alu_sequencer #(.WORDSIZE(16), .CMD_WIDTH(4), .TIMEOUT(4)) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
        .i_req_use_flags(req_uf), .i_req_flags(req_fl),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_result(resp_result), .o_resp_flags(resp_flags), .o_resp_error(resp_error),
        .o_bus_command(bus_cmd), .o_bus_data(bus_dout), .o_bus_valid(bus_vout),
        .i_bus_data(bus_din), .i_bus_valid(bus_vin)
    );

    // Behavioural ALU: flags bit0 = carry, bit1 = zero.
    logic [15:0] rA = '0, rB = '0, rY = '0;
    logic [3:0]  rOp = '0;
    logic [7:0]  rF = '0;
    logic [16:0] sum;
    assign sum     = {1'b0, rA} + {1'b0, rB} + ((rOp == OP_ADC) ? {16'd0, rF[0]} : 17'd0);
    assign bus_din = (bus_cmd == C_OY) ? rY : (bus_cmd == C_OF) ? {8'h00, rF} : 16'h0000;
    assign bus_vin = ((bus_cmd == C_OY) && !stall_y) || (bus_cmd == C_OF);

    always @(posedge clk) begin
        if (bus_vout) begin
            case (bus_cmd)
                C_LA:    rA  <= bus_dout;
                C_LB:    rB  <= bus_dout;
                C_LOP:   rOp <= bus_dout[3:0];
                C_LF:    rF  <= bus_dout[7:0];
                default: ;
            endcase
        end
        if (bus_cmd == C_CMP) begin
            rY <= sum[15:0];
            rF <= {6'b0, (sum[15:0] == 16'h0000), sum[16]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and log the bus until the response appears.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                          input logic uf, input logic [7:0] fl);
        req_a = a; req_b = b; req_op = op; req_uf = uf; req_fl = fl; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 4'hF; req_fl = 8'hFF;
        cmdlog.delete(); datlog.delete();
        lat = 0;
        while (!resp_valid && lat < 20) begin
            cmdlog.push_back(bus_cmd);
            datlog.push_back(bus_dout);
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cmd", 32'(bus_cmd), 32'(C_NOP));
        chk("rst_bus_valid", 32'(bus_vout), 32'd0);
        chk("rst_bus_data", 32'(bus_dout), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_flags", 32'(resp_flags), 32'd0);
        chk("rst_error", 32'(resp_error), 32'd0);

        // ADD 3+4 without flags
        run_op(16'h0003, 16'h0004, OP_ADD, 1'b0, 8'h00);
        chk("add_latency", 32'(lat), 32'd6);
        chk("add_ncmd", 32'(cmdlog.size()), 32'd6);
        if (cmdlog.size() == 6) begin
            chk("add_cmd0", 32'(cmdlog[0]), 32'(C_LA));
            chk("add_dat0", 32'(datlog[0]), 32'h0003);
            chk("add_cmd1", 32'(cmdlog[1]), 32'(C_LB));
            chk("add_dat1", 32'(datlog[1]), 32'h0004);
            chk("add_cmd2", 32'(cmdlog[2]), 32'(C_LOP));
            chk("add_dat2", 32'(datlog[2]), 32'(OP_ADD));
            chk("add_cmd3", 32'(cmdlog[3]), 32'(C_CMP));
            chk("add_cmd4", 32'(cmdlog[4]), 32'(C_OY));
            chk("add_cmd5", 32'(cmdlog[5]), 32'(C_OF));
        end
        chk("add_result", 32'(resp_result), 32'h0007);
        chk("add_flags", 32'(resp_flags), 32'h00);
        chk("add_error", 32'(resp_error), 32'd0);
        chk("resp_cmd_nop", 32'(bus_cmd), 32'(C_NOP));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        handshake();
        chk("hs_resp_valid", 32'(resp_valid), 32'd0);
        chk("hs_req_ready", 32'(req_ready), 32'd1);

        // ADD with carry-out and zero result
        run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 8'h00);
        chk("wrap_result", 32'(resp_result), 32'h0000);
        chk("wrap_flags", 32'(resp_flags), 32'h03);
        handshake();

        // ADC with carry-in loaded through LATCHF
        run_op(16'h0001, 16'h0001, OP_ADC, 1'b1, 8'h01);
        chk("adc_latency", 32'(lat), 32'd7);
        if (cmdlog.size() == 7) begin
            chk("adc_cmd3", 32'(cmdlog[3]), 32'(C_LF));
            chk("adc_dat3", 32'(datlog[3]), 32'h0001);
            chk("adc_cmd4", 32'(cmdlog[4]), 32'(C_CMP));
        end else begin
            chk("adc_ncmd", 32'(cmdlog.size()), 32'd7);
        end
        chk("adc_result", 32'(resp_result), 32'h0003);
        chk("adc_flags", 32'(resp_flags), 32'h00);
        handshake();

        // ALU never answers OUTPUTY: four cycles then timeout, OUTPUTF still issued
        stall_y = 1'b1;
        run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 8'h00);
        stall_y = 1'b0;
        chk("tmo_latency", 32'(lat), 32'd9);
        if (cmdlog.size() == 9) begin
            chk("tmo_cmd4", 32'(cmdlog[4]), 32'(C_OY));
            chk("tmo_cmd7", 32'(cmdlog[7]), 32'(C_OY));
            chk("tmo_cmd8", 32'(cmdlog[8]), 32'(C_OF));
        end
        chk("tmo_result", 32'(resp_result), 32'h0000);
        chk("tmo_error", 32'(resp_error), 32'd1);
        chk("tmo_flags", 32'(resp_flags), 32'h03);
        handshake();
        chk("tmo_error_clr", 32'(resp_error), 32'd0);

        // Backpressure with a second request waiting
        run_op(16'h0100, 16'h0023, OP_ADD, 1'b0, 8'h00);
        hold_res = resp_result;
        chk("bp_result", 32'(resp_result), 32'h0123);
        req_a = 16'h0002; req_b = 16'h0002; req_op = OP_ADD; req_uf = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_result_held", 32'(resp_result), 32'(hold_res));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_cmd_nop", 32'(bus_cmd), 32'(C_NOP));
        end
        handshake();
        chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
        chk("bp_not_yet_accepted", 32'(bus_cmd), 32'(C_NOP));
        run_op(16'h0002, 16'h0002, OP_ADD, 1'b0, 8'h00);
        chk("bp2_latency", 32'(lat), 32'd6);
        chk("bp2_result", 32'(resp_result), 32'h0004);
        handshake();

        // Reset while in COMPUTE, then a clean ADD
        req_a = 16'h0010; req_b = 16'h0020; req_op = OP_ADD; req_uf = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_cmd_compute", 32'(bus_cmd), 32'(C_CMP));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_cmd_nop", 32'(bus_cmd), 32'(C_NOP));
        run_op(16'h0010, 16'h0020, OP_ADD, 1'b0, 8'h00);
        chk("post_rst_latency", 32'(lat), 32'd6);
        chk("post_rst_result", 32'(resp_result), 32'h0030);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
